tlb_write_ctrl: RTL and testbench



---
 rtl/tlb_pkg.sv | 46 ++++
 rtl/tlb_write_ctrl_if.sv | 37 +++
 rtl/tlb_entry_pack.sv | 57 +++++
 rtl/tlb_write_ctrl.sv | 131 +++++++++++++
 tb/tb_tlb_write_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB types and packed-entry field layout, common to the write controller
// and the combinational lookup units.
package tlb_pkg;

   localparam int unsigned TLB_ENTRY_NUM   = 16;
   localparam int unsigned TLB_ENTRY_WIDTH = 96;
   localparam int unsigned TLB_INDEX_W     = 4;

   localparam int unsigned VPN2_W = 19;
   localparam int unsigned ASID_W = 8;
   localparam int unsigned PFN_W  = 20;
   localparam int unsigned C_W    = 3;

   localparam int unsigned VPN2_LSB = 0;
   localparam int unsigned ASID_LSB = 24;
   localparam int unsigned PFN1_LSB = 32;
   localparam int unsigned C1_LSB   = 58;
   localparam int unsigned D1_BIT   = 61;
   localparam int unsigned V1_BIT   = 62;
   localparam int unsigned G_BIT    = 63;
   localparam int unsigned PFN0_LSB = 64;
   localparam int unsigned C0_LSB   = 90;
   localparam int unsigned D0_BIT   = 93;
   localparam int unsigned V0_BIT   = 94;

   typedef logic [TLB_ENTRY_WIDTH-1:0]     TLB_entry_t;
   typedef TLB_entry_t [TLB_ENTRY_NUM-1:0] TLB_entries_t;
   typedef logic [TLB_INDEX_W-1:0]         TLB_index_t;

   localparam TLB_index_t TLB_INDEX_MAX = TLB_INDEX_W'(TLB_ENTRY_NUM - 1);

   typedef enum logic [1:0] {
      OP_TLBR  = 2'd0,
      OP_TLBWI = 2'd1,
      OP_TLBWR = 2'd2,
      OP_TLBP  = 2'd3
   } tlb_op_t;

   // CP0 EntryHi/EntryLo0/EntryLo1 triple in MIPS register format
   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo0;
      logic [31:0] lo1;
   } cp0_entry_t;

endpackage

// File: rtl/tlb_write_ctrl_if.sv
// CP0/EX-side request bus and TLB result/array bus of the write controller.
interface tlb_write_ctrl_if;
   import tlb_pkg::*;

   logic         req_i;
   tlb_op_t      op_i;
   TLB_index_t   index_i;
   TLB_index_t   wired_i;
   logic         wired_we_i;
   logic [31:0]  entry_hi_i;
   logic [31:0]  entry_lo0_i;
   logic [31:0]  entry_lo1_i;

   TLB_entries_t entries_o;
   TLB_index_t   random_o;
   logic         busy_o;
   logic         done_o;
   logic [31:0]  rd_entry_hi_o;
   logic [31:0]  rd_entry_lo0_o;
   logic [31:0]  rd_entry_lo1_o;
   logic [31:0]  probe_index_o;

   modport master (
      output req_i, op_i, index_i, wired_i, wired_we_i,
             entry_hi_i, entry_lo0_i, entry_lo1_i,
      input  entries_o, random_o, busy_o, done_o,
             rd_entry_hi_o, rd_entry_lo0_o, rd_entry_lo1_o, probe_index_o
   );

   modport slave (
      input  req_i, op_i, index_i, wired_i, wired_we_i,
             entry_hi_i, entry_lo0_i, entry_lo1_i,
      output entries_o, random_o, busy_o, done_o,
             rd_entry_hi_o, rd_entry_lo0_o, rd_entry_lo1_o, probe_index_o
   );

endinterface

// File: rtl/tlb_entry_pack.sv
// Combinational CP0 <-> packed TLB entry conversion; UNPACK selects the direction.
// Pack: data_i is a cp0_entry_t, data_o a TLB_entry_t. Unpack: the reverse.
module tlb_entry_pack
   import tlb_pkg::*;
#(
   parameter bit UNPACK = 1'b0
) (
   input  logic [TLB_ENTRY_WIDTH-1:0] data_i,
   output logic [TLB_ENTRY_WIDTH-1:0] data_o
);

   if (UNPACK == 1'b0) begin : g_pack
      cp0_entry_t cp0;
      TLB_entry_t ent;
      logic       unused_bits;

      assign cp0 = cp0_entry_t'(data_i);

      // Global bit is only set when both halves are global
      always_comb begin
         ent                        = '0;
         ent[VPN2_LSB +: VPN2_W]    = cp0.hi[31:13];
         ent[ASID_LSB +: ASID_W]    = cp0.hi[7:0];
         ent[PFN1_LSB +: PFN_W]     = cp0.lo1[25:6];
         ent[C1_LSB +: C_W]         = cp0.lo1[5:3];
         ent[D1_BIT]                = cp0.lo1[2];
         ent[V1_BIT]                = cp0.lo1[1];
         ent[G_BIT]                 = cp0.lo0[0] & cp0.lo1[0];
         ent[PFN0_LSB +: PFN_W]     = cp0.lo0[25:6];
         ent[C0_LSB +: C_W]         = cp0.lo0[5:3];
         ent[D0_BIT]                = cp0.lo0[2];
         ent[V0_BIT]                = cp0.lo0[1];
      end

      assign data_o      = ent;
      assign unused_bits = ^{cp0.hi[12:8], cp0.lo0[31:26], cp0.lo1[31:26]};
   end else begin : g_unpack
      TLB_entry_t ent;
      cp0_entry_t cp0;
      logic       unused_bits;

      assign ent = data_i;

      always_comb begin
         cp0     = '0;
         cp0.hi  = {ent[VPN2_LSB +: VPN2_W], 5'b0, ent[ASID_LSB +: ASID_W]};
         cp0.lo0 = {6'b0, ent[PFN0_LSB +: PFN_W], ent[C0_LSB +: C_W],
                    ent[D0_BIT], ent[V0_BIT], ent[G_BIT]};
         cp0.lo1 = {6'b0, ent[PFN1_LSB +: PFN_W], ent[C1_LSB +: C_W],
                    ent[D1_BIT], ent[V1_BIT], ent[G_BIT]};
      end

      assign data_o      = cp0;
      assign unused_bits = ^{ent[23:19], ent[57:52], ent[89:84], ent[95]};
   end

endmodule

// File: rtl/tlb_write_ctrl.sv
// TLB storage owner: executes TLBR/TLBWI/TLBWR in one cycle, TLBP as an ascending
// one-entry-per-cycle scan, and maintains the CP0 Random register.
module tlb_write_ctrl
   import tlb_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   tlb_write_ctrl_if.slave bus
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_PROBE = 1'b1
   } state_t;

   state_t       state_q, state_d;
   TLB_index_t   ptr_q, ptr_d;
   TLB_index_t   random_q, random_d;
   TLB_entries_t entries_q, entries_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   cp0_entry_t   rd_q, rd_d;
   logic [31:0]  probe_index_q, probe_index_d;

   TLB_entry_t   wr_entry_c;
   cp0_entry_t   rd_cp0_c;
   logic         match_c;

   tlb_entry_pack #(.UNPACK(1'b0)) u_wr_pack (
      .data_i ({bus.entry_hi_i, bus.entry_lo0_i, bus.entry_lo1_i}),
      .data_o (wr_entry_c)
   );

   tlb_entry_pack #(.UNPACK(1'b1)) u_rd_unpack (
      .data_i (entries_q[bus.index_i]),
      .data_o (rd_cp0_c)
   );

   // Probe compare for the entry under the scan pointer
   assign match_c =
      (entries_q[ptr_q][VPN2_LSB +: VPN2_W] == bus.entry_hi_i[31:13]) &&
      ((entries_q[ptr_q][ASID_LSB +: ASID_W] == bus.entry_hi_i[7:0]) ||
       entries_q[ptr_q][G_BIT]);

   // Random wraps to the top after reaching Wired; a Wired write restarts it
   always_comb begin
      random_d = random_q - TLB_index_t'(1);
      if (bus.wired_we_i || (random_q == bus.wired_i)) begin
         random_d = TLB_INDEX_MAX;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      entries_d     = entries_q;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      rd_d          = rd_q;
      probe_index_d = probe_index_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_i) begin
               unique case (bus.op_i)
                  OP_TLBR: begin
                     rd_d   = rd_cp0_c;
                     done_d = 1'b1;
                  end
                  OP_TLBWI: begin
                     entries_d[bus.index_i] = wr_entry_c;
                     done_d                 = 1'b1;
                  end
                  OP_TLBWR: begin
                     entries_d[random_q] = wr_entry_c;
                     done_d              = 1'b1;
                  end
                  OP_TLBP: begin
                     state_d = S_PROBE;
                     ptr_d   = '0;
                     busy_d  = 1'b1;
                  end
               endcase
            end
         end
         S_PROBE: begin
            busy_d = 1'b1;
            if (match_c || (ptr_q == TLB_INDEX_MAX)) begin
               state_d       = S_IDLE;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               probe_index_d = match_c ? {28'b0, ptr_q} : 32'h8000_0000;
            end else begin
               ptr_d = ptr_q + TLB_index_t'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         random_q      <= TLB_INDEX_MAX;
         entries_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         rd_q          <= '0;
         probe_index_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         random_q      <= random_d;
         entries_q     <= entries_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         rd_q          <= rd_d;
         probe_index_q <= probe_index_d;
      end
   end

   assign bus.entries_o      = entries_q;
   assign bus.random_o       = random_q;
   assign bus.busy_o         = busy_q;
   assign bus.done_o         = done_q;
   assign bus.rd_entry_hi_o  = rd_q.hi;
   assign bus.rd_entry_lo0_o = rd_q.lo0;
   assign bus.rd_entry_lo1_o = rd_q.lo1;
   assign bus.probe_index_o  = probe_index_q;

endmodule

// File: tb/tb_tlb_write_ctrl.sv
// Self-checking bench for tlb_write_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized ops against a field-level TLB model.
module tb_tlb_write_ctrl;
   import tlb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tlb_write_ctrl_if bus ();

   tlb_write_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: the CP0 triple last written to each entry, current Wired, Random age
   logic [31:0] m_hi [16];
   logic [31:0] m_lo0[16];
   logic [31:0] m_lo1[16];
   int          m_wired = 0;
   int          rand_age;

   always @(posedge clk or posedge rst) begin
      if (rst)                 rand_age <= 0;
      else if (bus.wired_we_i) rand_age <= 0;
      else                     rand_age <= rand_age + 1;
   end

   typedef struct {
      tlb_op_t     op;
      logic [3:0]  idx;
      logic [31:0] hi;
      logic [31:0] lo0;
      logic [31:0] lo1;
      logic [31:0] e_a;
      logic [31:0] e_b;
      logic [31:0] e_c;
      int          lat;
   } vec_t;

   vec_t tbl[12];

   function automatic logic [3:0] exp_rand();
      return 4'(15 - (rand_age % (16 - m_wired)));
   endfunction

   function automatic logic exp_g(input int i);
      return m_lo0[i][0] & m_lo1[i][0];
   endfunction

   function automatic logic [95:0] exp_pack(input int i);
      logic [95:0] e = '0;
      e[18:0]  = m_hi[i][31:13];
      e[31:24] = m_hi[i][7:0];
      e[51:32] = m_lo1[i][25:6];
      e[60:58] = m_lo1[i][5:3];
      e[61]    = m_lo1[i][2];
      e[62]    = m_lo1[i][1];
      e[63]    = exp_g(i);
      e[83:64] = m_lo0[i][25:6];
      e[92:90] = m_lo0[i][5:3];
      e[93]    = m_lo0[i][2];
      e[94]    = m_lo0[i][1];
      return e;
   endfunction

   function automatic int exp_probe(input logic [31:0] hi);
      for (int i = 0; i < 16; i++) begin
         if (m_hi[i][31:13] == hi[31:13] && (m_hi[i][7:0] == hi[7:0] || exp_g(i)))
            return i;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_entries();
      for (int i = 0; i < 16; i++)
         chk($sformatf("entry%0d", i), bus.entries_o[i], exp_pack(i));
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0;
      end
   endtask

   task automatic set_wired(input int w);
      bus.wired_i    = 4'(w);
      bus.wired_we_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.wired_we_i = 1'b0;
      m_wired        = w;
   endtask

   // Issue one op at a negedge; returns at the negedge of the done cycle
   task automatic run_op(input tlb_op_t op, input logic [3:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1, input int exp_lat);
      logic [3:0] tgt;
      int         lat;
      int         busy_low;
      tgt = (op == OP_TLBWR) ? exp_rand() : idx;
      chk("random_at_accept", 96'(bus.random_o), 96'(exp_rand()));
      bus.req_i       = 1'b1;
      bus.op_i        = op;
      bus.index_i     = idx;
      bus.entry_hi_i  = hi;
      bus.entry_lo0_i = lo0;
      bus.entry_lo1_i = lo1;
      @(posedge clk);
      @(negedge clk);
      bus.req_i = 1'b0;
      lat       = 1;
      busy_low  = 0;
      while (bus.done_o !== 1'b1 && lat < 20) begin
         if (bus.busy_o !== 1'b1) busy_low++;
         @(negedge clk);
         lat++;
      end
      chk($sformatf("latency op%0d", op), 96'(lat), 96'(exp_lat));
      chk("busy_during_op", 96'(busy_low), 96'(0));
      chk("busy_at_done", 96'(bus.busy_o), 96'(0));
      if (op == OP_TLBWI || op == OP_TLBWR) begin
         m_hi[tgt] = hi; m_lo0[tgt] = lo0; m_lo1[tgt] = lo1;
         chk_entries();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [18:0] vpn_pool[4];
      logic [7:0]  asid_pool[2];
      int          guard;
      int          lat;
      int          dones;

      vpn_pool  = '{19'h0, 19'h1, 19'h2ABCD, 19'h7FFFF};
      asid_pool = '{8'h00, 8'h5A};

      tbl[0]  = '{OP_TLBWI, 4'd3,  32'h0040_2005, 32'h0000_1047, 32'h0000_1086, 0, 0, 0, 1};
      tbl[1]  = '{OP_TLBR,  4'd3,  32'h0, 32'h0, 32'h0, 32'h0040_2005, 32'h0000_1046, 32'h0000_1086, 1};
      tbl[2]  = '{OP_TLBWI, 4'd5,  32'hABCD_E011, 32'h0000_2AC7, 32'h0000_2B05, 0, 0, 0, 1};
      tbl[3]  = '{OP_TLBWI, 4'd9,  32'hABCD_E011, 32'h0123_4567, 32'h0089_ABCD, 0, 0, 0, 1};
      tbl[4]  = '{OP_TLBP,  4'd0,  32'hABCD_E011, 32'h0, 32'h0, 32'd5, 0, 0, 7};
      tbl[5]  = '{OP_TLBP,  4'd0,  32'hFFFF_E0AA, 32'h0, 32'h0, 32'h8000_0000, 0, 0, 17};
      tbl[6]  = '{OP_TLBWI, 4'd2,  32'h5555_6033, 32'h0000_3FFF, 32'h03FF_FFC1, 0, 0, 0, 1};
      tbl[7]  = '{OP_TLBP,  4'd0,  32'h5555_60FF, 32'h0, 32'h0, 32'd2, 0, 0, 4};
      tbl[8]  = '{OP_TLBP,  4'd0,  32'h0000_0000, 32'h0, 32'h0, 32'd0, 0, 0, 2};
      tbl[9]  = '{OP_TLBR,  4'd2,  32'h0, 32'h0, 32'h0, 32'h5555_6033, 32'h0000_3FFF, 32'h03FF_FFC1, 1};
      tbl[10] = '{OP_TLBWI, 4'd15, 32'h7777_7042, 32'h0000_0F00, 32'h0000_00F0, 0, 0, 0, 1};
      tbl[11] = '{OP_TLBP,  4'd0,  32'h7777_7042, 32'h0, 32'h0, 32'd15, 0, 0, 17};

      rst             = 1'b1;
      bus.req_i       = 1'b0;
      bus.op_i        = OP_TLBR;
      bus.index_i     = '0;
      bus.wired_i     = '0;
      bus.wired_we_i  = 1'b0;
      bus.entry_hi_i  = '0;
      bus.entry_lo0_i = '0;
      bus.entry_lo1_i = '0;
      model_clear();

      // Reset values
      repeat (3) @(negedge clk);
      chk_entries();
      chk("rst_random", 96'(bus.random_o), 96'(15));
      chk("rst_busy", 96'(bus.busy_o), 96'(0));
      chk("rst_done", 96'(bus.done_o), 96'(0));
      chk("rst_rd_hi", 96'(bus.rd_entry_hi_o), 96'(0));
      chk("rst_probe", 96'(bus.probe_index_o), 96'(0));
      rst = 1'b0;

      // Random countdown with Wired=0, then Wired=10
      for (int n = 0; n < 17; n++) begin
         chk($sformatf("random_w0_c%0d", n), 96'(bus.random_o), 96'((n < 16) ? 15 - n : 15));
         @(negedge clk);
      end
      set_wired(10);
      for (int n = 0; n < 7; n++) begin
         chk($sformatf("random_w10_c%0d", n), 96'(bus.random_o), 96'((n < 6) ? 15 - n : 15));
         @(negedge clk);
      end
      set_wired(0);

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].op, tbl[i].idx, tbl[i].hi, tbl[i].lo0, tbl[i].lo1, tbl[i].lat);
         if (tbl[i].op == OP_TLBR) begin
            chk($sformatf("vec%0d rd_hi", i),  96'(bus.rd_entry_hi_o),  96'(tbl[i].e_a));
            chk($sformatf("vec%0d rd_lo0", i), 96'(bus.rd_entry_lo0_o), 96'(tbl[i].e_b));
            chk($sformatf("vec%0d rd_lo1", i), 96'(bus.rd_entry_lo1_o), 96'(tbl[i].e_c));
         end else if (tbl[i].op == OP_TLBP) begin
            chk($sformatf("vec%0d probe", i), 96'(bus.probe_index_o), 96'(tbl[i].e_a));
         end
      end

      // TLBWR lands on the Random value present at the accepting edge
      guard = 0;
      while (exp_rand() != 4'd7 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("tlbwr_random_is_7", 96'(bus.random_o), 96'(7));
      run_op(OP_TLBWR, 4'd0, 32'h0BAD_0001, 32'h0000_5555, 32'h0000_AAAA, 1);

      // Strobe while busy is dropped
      bus.req_i      = 1'b1;
      bus.op_i       = OP_TLBP;
      bus.entry_hi_i = 32'hABCD_E011;
      @(posedge clk);
      @(negedge clk);
      bus.req_i = 1'b0;
      lat       = 1;
      while (bus.done_o !== 1'b1 && lat < 20) begin
         if (lat == 3) begin
            bus.req_i       = 1'b1;
            bus.op_i        = OP_TLBWI;
            bus.index_i     = 4'd5;
            bus.entry_lo0_i = 32'hFFFF_FFFF;
            bus.entry_lo1_i = 32'hFFFF_FFFF;
         end else begin
            bus.req_i = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.req_i = 1'b0;
      chk("drop_probe_latency", 96'(lat), 96'(7));
      chk("drop_probe_index", 96'(bus.probe_index_o), 96'(5));
      chk_entries();
      @(negedge clk);
      chk("drop_no_extra_done", 96'(bus.done_o), 96'(0));

      // Reset during probe aborts it
      bus.req_i      = 1'b1;
      bus.op_i       = OP_TLBP;
      bus.entry_hi_i = 32'hFFFF_E0AA;
      @(posedge clk);
      @(negedge clk);
      bus.req_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 96'(bus.busy_o), 96'(1));
      rst = 1'b1;
      #1;
      model_clear();
      chk_entries();
      chk("midrst_random", 96'(bus.random_o), 96'(15));
      chk("midrst_busy", 96'(bus.busy_o), 96'(0));
      chk("midrst_done", 96'(bus.done_o), 96'(0));
      chk("midrst_rd_lo0", 96'(bus.rd_entry_lo0_o), 96'(0));
      chk("midrst_probe", 96'(bus.probe_index_o), 96'(0));
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int n = 0; n < 20; n++) begin
         if (bus.done_o === 1'b1) dones++;
         @(negedge clk);
      end
      chk("midrst_no_done", 96'(dones), 96'(0));

      // Randomized ops against the model
      for (int n = 0; n < 80; n++) begin
         tlb_op_t     op;
         logic [3:0]  idx;
         logic [31:0] hi, lo0, lo1;
         logic [31:0] e_hi, e_lo0, e_lo1;
         int          p;
         int          elat;
         if ($urandom_range(0, 9) == 0) set_wired(int'($urandom_range(0, 15)));
         op  = tlb_op_t'($urandom_range(0, 3));
         idx = 4'($urandom_range(0, 15));
         hi  = {vpn_pool[$urandom_range(0, 3)], 5'($urandom), asid_pool[$urandom_range(0, 1)]};
         lo0 = $urandom;
         lo1 = $urandom;
         p   = exp_probe(hi);
         elat  = (op != OP_TLBP) ? 1 : ((p < 0) ? 17 : p + 2);
         e_hi  = {m_hi[idx][31:13], 5'b0, m_hi[idx][7:0]};
         e_lo0 = {6'b0, m_lo0[idx][25:1], exp_g(idx)};
         e_lo1 = {6'b0, m_lo1[idx][25:1], exp_g(idx)};
         run_op(op, idx, hi, lo0, lo1, elat);
         if (op == OP_TLBR) begin
            chk($sformatf("rnd%0d rd_hi", n),  96'(bus.rd_entry_hi_o),  96'(e_hi));
            chk($sformatf("rnd%0d rd_lo0", n), 96'(bus.rd_entry_lo0_o), 96'(e_lo0));
            chk($sformatf("rnd%0d rd_lo1", n), 96'(bus.rd_entry_lo1_o), 96'(e_lo1));
         end else if (op == OP_TLBP) begin
            chk($sformatf("rnd%0d probe", n), 96'(bus.probe_index_o),
                96'((p < 0) ? 32'h8000_0000 : 32'(p)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
